// File: rtl/cpu1_pkg.sv
// Shared constants and types for the CPU1 fetch/execute sequencer.
// Optional single-step support is enabled by defining CPU1_SINGLE_STEP_EN.
package cpu1_pkg;

   // Instruction opcodes, instr[7:4]
   localparam logic [3:0] OP_NOP    = 4'h0;
   localparam logic [3:0] OP_LDA    = 4'h1;
   localparam logic [3:0] OP_LDB    = 4'h2;
   localparam logic [3:0] OP_ADD    = 4'h3;
   localparam logic [3:0] OP_SUB    = 4'h4;
   localparam logic [3:0] OP_AND    = 4'h5;
   localparam logic [3:0] OP_OR     = 4'h6;
   localparam logic [3:0] OP_XOR    = 4'h7;
   localparam logic [3:0] OP_MRA    = 4'h8;
   localparam logic [3:0] OP_MRB    = 4'h9;
   localparam logic [3:0] OP_JMP    = 4'hA;
   localparam logic [3:0] OP_JZ     = 4'hB;
   localparam logic [3:0] OP_JNZ    = 4'hC;
   localparam logic [3:0] OP_RSVD_D = 4'hD;
   localparam logic [3:0] OP_RSVD_E = 4'hE;
   localparam logic [3:0] OP_HALT   = 4'hF;

   // ALU operation codes
   localparam logic [2:0] ALU_ADD = 3'd0;
   localparam logic [2:0] ALU_SUB = 3'd1;
   localparam logic [2:0] ALU_AND = 3'd2;
   localparam logic [2:0] ALU_OR  = 3'd3;
   localparam logic [2:0] ALU_XOR = 3'd4;

   // A/B input mux select
   localparam logic SRC_IMM = 1'b0;
   localparam logic SRC_R   = 1'b1;

   // Sequencer states; WAIT is only reachable in single-step builds
   typedef enum logic [1:0] {
      FETCH = 2'd0,
      EXEC  = 2'd1,
      HALT  = 2'd2,
      WAIT  = 2'd3
   } state_e;

endpackage

// File: rtl/cpu1_decode.sv
// Combinational decode of the latched opcode into datapath controls.
// Outputs are raw decode; the sequencer gates them with its EXEC state.
module cpu1_decode
   import cpu1_pkg::*;
(
   input  logic [3:0] opcode_i,
   input  logic       z_i,
   output logic       a_en_o,
   output logic       b_en_o,
   output logic       r_en_o,
   output logic       src_sel_o,
   output logic [2:0] alu_op_o,
   output logic       jump_taken_o,
   output logic       halt_o
);

   // Opcode to control mapping; reserved opcodes fall through as NOP
   always_comb begin
      a_en_o       = 1'b0;
      b_en_o       = 1'b0;
      r_en_o       = 1'b0;
      src_sel_o    = SRC_IMM;
      alu_op_o     = ALU_ADD;
      jump_taken_o = 1'b0;
      halt_o       = 1'b0;
      case (opcode_i)
         OP_LDA:  a_en_o = 1'b1;
         OP_LDB:  b_en_o = 1'b1;
         OP_ADD:  begin r_en_o = 1'b1; alu_op_o = ALU_ADD; end
         OP_SUB:  begin r_en_o = 1'b1; alu_op_o = ALU_SUB; end
         OP_AND:  begin r_en_o = 1'b1; alu_op_o = ALU_AND; end
         OP_OR:   begin r_en_o = 1'b1; alu_op_o = ALU_OR;  end
         OP_XOR:  begin r_en_o = 1'b1; alu_op_o = ALU_XOR; end
         OP_MRA:  begin a_en_o = 1'b1; src_sel_o = SRC_R; end
         OP_MRB:  begin b_en_o = 1'b1; src_sel_o = SRC_R; end
         OP_JMP:  jump_taken_o = 1'b1;
         OP_JZ:   jump_taken_o = z_i;
         OP_JNZ:  jump_taken_o = ~z_i;
         OP_HALT: halt_o = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: rtl/cpu1_sequencer.sv
// CPU1 fetch/execute control unit: FSM, program counter, instruction
// register and zero flag. Defining CPU1_SINGLE_STEP_EN adds step_i and a
// WAIT state that gates every fetch, including the first after reset.
module cpu1_sequencer
   import cpu1_pkg::*;
#(
   parameter int PC_W = 4
)(
   input  logic            clk_i,
   input  logic            rst_i,
`ifdef CPU1_SINGLE_STEP_EN
   input  logic            step_i,
`endif
   input  logic [7:0]      instr_i,
   input  logic            mem_ack_i,
   input  logic            alu_zero_i,
   output logic            mem_req_o,
   output logic [PC_W-1:0] pc_o,
   output logic            a_en_o,
   output logic            b_en_o,
   output logic            r_en_o,
   output logic            src_sel_o,
   output logic [3:0]      imm_o,
   output logic [2:0]      alu_op_o,
   output logic            halted_o
);

`ifdef CPU1_SINGLE_STEP_EN
   localparam state_e RESET_STATE = WAIT;
   localparam state_e AFTER_EXEC  = WAIT;
`else
   localparam state_e RESET_STATE = FETCH;
   localparam state_e AFTER_EXEC  = FETCH;
`endif

   state_e          state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic [7:0]      ir_q, ir_d;
   logic            z_q, z_d;

   logic            dec_a_en, dec_b_en, dec_r_en, dec_src_sel;
   logic [2:0]      dec_alu_op;
   logic            dec_jump, dec_halt;
   logic            in_exec;

   cpu1_decode u_decode (
      .opcode_i     (ir_q[7:4]),
      .z_i          (z_q),
      .a_en_o       (dec_a_en),
      .b_en_o       (dec_b_en),
      .r_en_o       (dec_r_en),
      .src_sel_o    (dec_src_sel),
      .alu_op_o     (dec_alu_op),
      .jump_taken_o (dec_jump),
      .halt_o       (dec_halt)
   );

   // State, pc, instruction and zero-flag registers
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= RESET_STATE;
         pc_q    <= '0;
         ir_q    <= {OP_NOP, 4'h0};
         z_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
         z_q     <= z_d;
      end
   end

   // Next-state logic: latch on ack, execute for one cycle, update pc and z
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ir_d    = ir_q;
      z_d     = z_q;
      case (state_q)
         FETCH: begin
            if (mem_ack_i) begin
               ir_d    = instr_i;
               state_d = EXEC;
            end
         end
         EXEC: begin
            if (dec_r_en) begin
               z_d = alu_zero_i;
            end
            if (dec_halt) begin
               state_d = HALT;
            end else begin
               state_d = AFTER_EXEC;
               // Operand is zero-extended to the pc width on a taken jump
               pc_d    = dec_jump ? PC_W'(ir_q[3:0]) : pc_q + PC_W'(1);
            end
         end
         HALT: ;
         WAIT: begin
`ifdef CPU1_SINGLE_STEP_EN
            if (step_i) begin
               state_d = FETCH;
            end
`else
            state_d = FETCH;
`endif
         end
         default: state_d = RESET_STATE;
      endcase
   end

   // Controls are only live during EXEC; everything else reflects the state
   always_comb begin
      in_exec   = (state_q == EXEC);
      a_en_o    = in_exec & dec_a_en;
      b_en_o    = in_exec & dec_b_en;
      r_en_o    = in_exec & dec_r_en;
      src_sel_o = in_exec ? dec_src_sel : SRC_IMM;
      alu_op_o  = in_exec ? dec_alu_op : ALU_ADD;
      imm_o     = ir_q[3:0];
      mem_req_o = (state_q == FETCH);
      halted_o  = (state_q == HALT);
      pc_o      = pc_q;
   end

endmodule
